// File: rtl/ram_boot_loader.sv
// Boot loader: receives a big-endian 16-bit word count and then that many
// big-endian 16-bit words from a byte stream, writing them to RAM from address 0.
module ram_boot_loader #(
   parameter int MAX_WORDS = 3584
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [11:0] address,
   output logic [15:0] out,
   output logic        load,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [11:0] count
);

   typedef enum logic [3:0] {
      IDLE, LEN_HI, LEN_LO, CHECK, DATA_HI, DATA_LO, WRITE, DONE, ERROR
   } state_t;

   localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

   state_t      state, state_next;
   logic [15:0] length;
   logic [7:0]  data_hi;
   logic        accept;
   logic [11:0] count_inc;

   assign rx_ready  = (state == LEN_HI) || (state == LEN_LO) ||
                      (state == DATA_HI) || (state == DATA_LO);
   assign accept    = rx_valid & rx_ready;
   assign load      = (state == WRITE);
   assign busy      = (state == LEN_HI) || (state == LEN_LO) || (state == CHECK) ||
                      (state == DATA_HI) || (state == DATA_LO) || (state == WRITE);
   assign done      = (state == DONE);
   assign error     = (state == ERROR);
   assign count_inc = count + 12'd1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE, DONE, ERROR: if (start) state_next = LEN_HI;
         LEN_HI:            if (accept) state_next = LEN_LO;
         LEN_LO:            if (accept) state_next = CHECK;
         // Full 16-bit compare so lengths like 0x1001 cannot alias into range
         CHECK: begin
            if (length == 16'd0)         state_next = DONE;
            else if (length > MAX_LEN)   state_next = ERROR;
            else                         state_next = DATA_HI;
         end
         DATA_HI:           if (accept) state_next = DATA_LO;
         DATA_LO:           if (accept) state_next = WRITE;
         WRITE:             state_next = ({4'd0, count_inc} == length) ? DONE : DATA_HI;
         default:           state_next = IDLE;
      endcase
   end

   // Address and data are captured with the low byte so they are stable through
   // WRITE and keep their last value afterwards; a half-received word never leaks out.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         length  <= 16'd0;
         data_hi <= 8'd0;
         address <= 12'd0;
         out     <= 16'd0;
         count   <= 12'd0;
      end else begin
         case (state)
            IDLE, DONE, ERROR: if (start) count <= 12'd0;
            LEN_HI:            if (accept) length[15:8] <= rx_data;
            LEN_LO:            if (accept) length[7:0] <= rx_data;
            DATA_HI:           if (accept) data_hi <= rx_data;
            DATA_LO: begin
               if (accept) begin
                  address <= count;
                  out     <= {data_hi, rx_data};
               end
            end
            WRITE:             count <= count_inc;
            default: ;
         endcase
      end
   end

endmodule

// File: doc/ram_boot_loader.md
RAM_BOOT_LOADER -- requirements
Module: ram_boot_loader

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 3584, the highest accepted image length in words (populated RAM depth, 7 x 512).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit; reset is asynchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit, a one-cycle request that begins a load.
REQ-005 SHALL have port rx_data, input, 8 bits, the byte stream from the serial receiver.
REQ-006 SHALL have port rx_valid, input, 1 bit, set when rx_data holds a byte.
REQ-007 SHALL have port rx_ready, output, 1 bit; a byte is consumed on a cycle with rx_valid&rx_ready.
REQ-008 SHALL have port address, output, 12 bits, the RAM word address.
REQ-009 SHALL have port out, output, 16 bits, the RAM write data.
REQ-010 SHALL have port load, output, 1 bit, the RAM write enable.
REQ-011 SHALL have port busy, output, 1 bit, high while a load is in progress.
REQ-012 SHALL have port done, output, 1 bit, held high after a successful load.
REQ-013 SHALL have port error, output, 1 bit, held high after a rejected length.
REQ-014 SHALL have port count, output, 12 bits, the number of words written so far.

Function
REQ-015 SHALL implement the states IDLE, LEN_HI, LEN_LO, CHECK, DATA_HI, DATA_LO, WRITE, DONE and ERROR.
REQ-016 SHALL leave IDLE, DONE or ERROR for LEN_HI on start=1, clearing done, error and count on that edge; start SHALL be ignored in every other state.
REQ-017 SHALL assert rx_ready only in LEN_HI, LEN_LO, DATA_HI and DATA_LO, combinationally from state.
REQ-018 SHALL wait in any byte state without limit while rx_valid=0, with no timeout.
REQ-019 SHALL assemble the image length N big-endian from the LEN_HI byte (bits 15:8) and the LEN_LO byte (bits 7:0), then enter CHECK.
REQ-020 CHECK, 1 cycle: N=0 -> DONE; N>MAX_WORDS -> ERROR; else -> DATA_HI.
REQ-021 SHALL assemble each data word big-endian, first byte in bits 15:8, and enter WRITE after the DATA_LO byte is accepted.
REQ-022 WRITE, 1 cycle: load=1, address=count, out=the assembled word; count increments on the exiting edge.
REQ-023 Leaving WRITE: go to DONE if the incremented count equals N, else to DATA_HI.
REQ-024 Per word, the minimum is 3 cycles (2 byte handshakes + WRITE); rx_ready SHALL be 0 during WRITE and CHECK.
REQ-025 load SHALL be 0 in every state except WRITE; address and out SHALL hold their last values outside WRITE.
REQ-026 busy SHALL be 1 in LEN_HI through WRITE, and 0 in IDLE, DONE and ERROR.
REQ-027 count SHALL never exceed MAX_WORDS; address SHALL never exceed MAX_WORDS-1 when load=1.
REQ-028 Bytes offered in IDLE, DONE or ERROR SHALL be left unconsumed (rx_ready=0).
REQ-029 N is 16 bits; the comparison against MAX_WORDS SHALL use the full 16 bits, so no truncation aliasing is allowed.

Reset
REQ-030 reset=1 SHALL immediately force state IDLE and set rx_ready, load, busy, done and error to 0, count to 0, address to 0 and out to 0.
REQ-031 reset during a transfer SHALL abort it; words already written stay in RAM, and a partial word SHALL be discarded.
REQ-032 After reset, the first start SHALL behave exactly as from power-up.

Verification
REQ-033 Stimulus: start, then bytes 00 02 12 34 AB CD. Response: load pulses at address 0 with out=0x1234 and at address 1 with out=0xABCD; done=1; count=2.
REQ-034 Stimulus: length 0x0000. Response: done=1 two cycles after the LEN_LO handshake, with no load pulse.
REQ-035 Stimulus: length 0x0E01 (3585). Response: error=1, no load, and further bytes are not consumed (rx_ready=0).
REQ-036 Stimulus: length 0x0E00 with rx_valid toggled randomly. Response: 3584 writes to addresses 0..3583 in order; the last write is at 0xDFF; count=3584; done=1.
REQ-037 Stimulus: reset asserted between the DATA_HI and DATA_LO bytes of word 5. Response: all outputs are 0 asynchronously and there is no load for word 5; a restart reloads from address 0.
